// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path: state codes,
// opcodes, datapath mux encodings and the packed control word.
package mcpu_pkg;

  localparam int STATE_W = 4;
  localparam int OP_W    = 6;

  localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB  = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR  = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC   = 4'd6;
  localparam logic [STATE_W-1:0] S_RWB    = 4'd7;
  localparam logic [STATE_W-1:0] S_BEQ    = 4'd8;
  localparam logic [STATE_W-1:0] S_JUMP   = 4'd9;
  localparam logic [STATE_W-1:0] S_ADDIEX = 4'd10;
  localparam logic [STATE_W-1:0] S_ADDIWB = 4'd11;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctl_if.sv
// Control bus between the main FSM (master) and the multicycle datapath (slave).
interface multicycle_ctl_if;
  import mcpu_pkg::*;

  logic [OP_W-1:0]    OP;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               illegal_op;
  logic               instr_done;
  logic [STATE_W-1:0] state;

  modport master (
    input  OP, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op,
           instr_done, state
  );

  modport slave (
    output OP, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op,
           instr_done, state
  );

endinterface

// File: rtl/mcpu_outdec.sv
// Moore output decoder: state (plus mem_ready for the memory-gated enables)
// to the datapath control word.
module mcpu_outdec
  import mcpu_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               mem_ready,
  output ctrl_t              ctrl
);

  always_comb begin
    // NOTE: default every field before the case so no path leaves a
    // combinational output unassigned, which would infer a latch.
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe is held for the whole wait; completion follows mem_ready.
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctl.sv
// Main control FSM of the multicycle MIPS-subset CPU: state register,
// next-state decode and a reset-gated Moore output stage.
module multicycle_ctl
  import mcpu_pkg::*;
#(
  parameter bit ADDI_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  multicycle_ctl_if.master bus
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               illegal;
  ctrl_t              ctrl_dec;
  ctrl_t              ctrl_o;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    unique case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI: begin
            if (ADDI_EN) state_d = S_ADDIEX;
            else         illegal = 1'b1;
          end
          default:      illegal = 1'b1;
        endcase
      end
      S_MEMADR: state_d = (bus.OP == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mcpu_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl_dec)
  );

  // Reset gates the outputs combinationally so strobes drop the instant rst
  // rises, not at the next clock edge.
  always_comb begin
    ctrl_o = rst ? '0 : ctrl_dec;
  end

  assign bus.PCWrite     = ctrl_o.pc_write;
  assign bus.PCWriteCond = ctrl_o.pc_write_cond;
  assign bus.IorD        = ctrl_o.iord;
  assign bus.MemRead     = ctrl_o.mem_read;
  assign bus.MemWrite    = ctrl_o.mem_write;
  assign bus.IRWrite     = ctrl_o.ir_write;
  assign bus.MemtoReg    = ctrl_o.mem_to_reg;
  assign bus.RegDst      = ctrl_o.reg_dst;
  assign bus.RegWrite    = ctrl_o.reg_write;
  assign bus.ALUSrcA     = ctrl_o.alu_src_a;
  assign bus.ALUSrcB     = ctrl_o.alu_src_b;
  assign bus.ALUOp       = ctrl_o.alu_op;
  assign bus.PCSource    = ctrl_o.pc_source;
  assign bus.instr_done  = ctrl_o.instr_done;
  assign bus.illegal_op  = illegal & ~rst;
  assign bus.state       = rst ? S_FETCH : state_q;

endmodule

// File: doc/multicycle_ctl.md
Name: multicycle_ctl

Overview:
- Moore-style main control FSM for the multicycle MIPS-subset CPU.
- Sequences one shared ALU, one unified instruction/data memory, the IR, PC and register file across 3–5 cycles per instruction.
- Supports R-type, lw, sw, beq, j and (optionally) addi.
- Adds a memory-ready wait handshake and an illegal-opcode flag.

Parameters:
- ADDI_EN, 1, when 1 decode addi (OP=001000); when 0 addi is treated as illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- OP  input  6  opcode from the IR (IR[31:26]), valid from DECODE onward.
- mem_ready  input  1  memory access completes this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU Zero (the Zero AND is in the datapath).
- IorD  output  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR load.
- MemtoReg  output  1  write-back source: 1 = MDR, 0 = ALUOut.
- RegDst  output  1  destination register: 1 = rd, 0 = rt.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  output  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct decode.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- instr_done  output  1  one-cycle pulse in an instruction's final state.
- state  output  4  current state, for debug.

Behaviour:
- State register is 4 bits. Reset asserts asynchronously: state := FETCH(0). While rst=1, every output is forced to 0 and `state` reads 0.
- Outputs are decoded from `state` only, except the write enables that are ANDed with mem_ready. All outputs not listed for a state are 0.

State outputs and transitions:
- FETCH(0): MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready. Go to DECODE if mem_ready, else stay.
- DECODE(1): ALUSrcB=11 (branch target into ALUOut). Next state by OP:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BEQ
  - 000010 -> JUMP
  - 001000 with ADDI_EN=1 -> ADDIEX
  - anything else -> FETCH, with illegal_op=1 this cycle
- MEMADR(2): ALUSrcA=1, ALUSrcB=10. Go to MEMRD if OP=lw, else MEMWR.
- MEMRD(3): MemRead=1, IorD=1. Go to MEMWB on mem_ready, else stay.
- MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Hold MemWrite until mem_ready. On mem_ready: instr_done=1, go to FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB(7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Go to FETCH.
- BEQ(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
- JUMP(9): PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
- ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
- ADDIWB(11): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Go to FETCH.
- Encodings 12–15: all outputs 0; next state FETCH.

Latencies and boundary cases:
- Zero-wait latencies: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- Each wait cycle adds one cycle.
- A mem_ready that arrives outside FETCH, MEMRD or MEMWR is ignored.
- OP is sampled only in DECODE and MEMADR. OP changes in other states have no effect.
- Reset asserted in any state, including mid-wait, aborts the access: strobes drop asynchronously and the FSM restarts at FETCH on the first edge after release.

Decomposition:
- Shared package `mcpu_pkg` holds:
  - state localparams S_FETCH … S_ADDIWB;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp, ALUSrcB and PCSource encodings.
- One sub-module is natural: `mcpu_outdec`, a purely combinational state+mem_ready -> control-word decoder. The FSM next-state logic stays in multicycle_ctl.

Test Plan:
- Reset held 3 cycles, then released, mem_ready=1 -> all outputs 0 during reset; cycle 1 after release: state=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- OP=100011, mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 only in state 4; instr_done high one cycle.
- OP=101011, mem_ready low 2 cycles in MEMWR -> MemWrite=1, IorD=1 for 3 consecutive cycles; FETCH follows the ready cycle; RegWrite never asserted.
- OP=000000, then 000100, then 000010 back-to-back -> 4, 3 and 3 cycles respectively; ALUOp=10 in EXEC; PCWriteCond=1 with ALUOp=01 in BEQ; PCWrite=1 with PCSource=10 in JUMP.
- OP=111111 -> illegal_op=1 for one cycle in DECODE, next state 0. With ADDI_EN=0 and OP=001000 -> same response.
- rst pulsed while in MEMRD waiting (mem_ready=0) -> MemRead drops immediately (asynchronously), state=0; after release, fetch resumes normally.
